data_mem_rr_arbiter: RTL
========================

// Module: data_mem_rr_arbiter
// PURPOSE
//  Shares one single-port data memory (AW-bit address, DW-bit data) between NREQ requesters.
//  Uses round-robin arbitration with one outstanding access at a time.
//  Sequences each access: accepts a read or write, drives the memory port,
//  waits RD_LAT cycles for read data, then returns the data to the requester that issued the read.
//  Sits between the testbench/driver agents and the shared data_mem / pixel store.
// PARAMETERS
//  NREQ    4   number of requesters (>=2)
//  AW      8   memory address width
//  DW      32  memory data width
//  RD_LAT  1   memory read latency in clk edges after mem_en is sampled (>=1)
// PORTS
//  clk        in   1         clock, rising edge
//  rst        in   1         reset, asynchronous, active-high
//  req        in   NREQ      per-requester access request, level
//  we         in   NREQ      per-requester write enable (1=write, 0=read)
//  addr       in   NREQ*AW   per-requester address, slice i = addr[i*AW +: AW]
//  wdata      in   NREQ*DW   per-requester write data, slice i = wdata[i*DW +: DW]
//  gnt        out  NREQ      one-hot accept pulse, one cycle
//  rvalid     out  NREQ      one-hot read-data-valid pulse, one cycle
//  rdata      out  DW        read data, shared, valid while rvalid!=0
//  mem_en     out  1         memory access strobe
//  mem_we     out  1         memory write enable
//  mem_addr   out  AW        memory address
//  mem_wdata  out  DW        memory write data
//  mem_rdata  in   DW        memory read data, valid RD_LAT edges after the mem_en sample edge
//  busy       out  1         high when the FSM is not in IDLE
// BEHAVIOUR
//  Reset values (async): state=IDLE; gnt=0; rvalid=0; rdata=0; mem_en=0; mem_we=0;
//   mem_addr=0; mem_wdata=0; last-grant pointer lg=NREQ-1; wait counter=0.
//  All outputs are registered; there is no combinational path from input to output.
//  FSM states:
//   IDLE  - arbitrates only in this state, at a clock edge where req!=0.
//   ISSUE - one cycle; the memory port is driven.
//   WAIT  - read only; counts RD_LAT edges.
//  Arbitration: winner = first set req bit, searching lg+1, lg+2, ... modulo NREQ.
//   At that edge (E0): lg<=winner; capture we/addr/wdata of the winner; gnt[winner]<=1;
//   mem_en<=1; mem_we/mem_addr/mem_wdata<=captured values; state<=ISSUE.
//  ISSUE, at edge E1: gnt<=0; mem_en<=0; mem_we<=0.
//   Write: state<=IDLE.
//   Read: state<=WAIT, counter<=1.
//  WAIT: counter increments each edge. At edge E(1+RD_LAT): rdata<=mem_rdata;
//   rvalid[owner]<=1; state<=IDLE. rvalid clears at the next edge.
//  Earliest next grant: write at E2; read at E(2+RD_LAT). Rate: 1 write per 2 cycles.
//  Handshake: requester holds req/we/addr/wdata stable until it samples gnt=1.
//   req still sampled high at the edge after gnt observed = a new access.
//   Non-winning requesters stay pending and are not dropped.
//   Dropping req before gnt is legal (withdrawal); no access is made.
//  Simultaneous events:
//   rvalid and a new gnt never share a cycle; grant is earliest one edge after rvalid.
//   Inputs changing during ISSUE/WAIT have no effect.
//  Boundaries:
//   lg wraps NREQ-1 -> 0.
//   Owner index width $clog2(NREQ); counter width $clog2(RD_LAT+1).
//   All addresses 0..2**AW-1 are legal; no address checking is done.
//  Reset mid-operation: an in-flight read is abandoned and no rvalid is issued.
//   Any late mem_rdata is ignored. Arbitration restarts from req[0] priority.
// TESTING
//  1. Reset: rst=1 for 2 cycles -> all outputs 0, busy=0. Then req=4'b1111 held
//     -> grant order 0,1,2,3,0.
//  2. Write: req[1] we=1 addr=8'h10 wdata=32'hDEADBEEF -> gnt=4'b0010 for one cycle,
//     with mem_en=1 mem_we=1 mem_addr=8'h10 mem_wdata=DEADBEEF in the same cycle.
//     busy high 1 cycle.
//  3. Read, RD_LAT=2: req[2] we=0 addr=8'h10 (model returns DEADBEEF)
//     -> rvalid=4'b0100 is high only in the cycle after the edge E0+3;
//     rdata=32'hDEADBEEF; gnt and rvalid never overlap.
//  4. Fairness: req[0] and req[3] held continuously, 8 writes -> grant sequence
//     0,3,0,3,0,3,0,3; no requester starves.
//  5. Wrap/skip: lg=3, req=4'b0110 -> gnt[1]. Then with req[1] dropped and req=4'b0100
//     -> gnt[2].
//  6. Reset mid-read: rst pulsed while in WAIT -> no rvalid pulse. After release,
//     req=4'b1001 -> first gnt is req0.

Source files
------------

// File: rtl/data_mem_rr_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between NREQ requesters.
// One access in flight at a time: IDLE -> ISSUE (-> WAIT for reads) -> IDLE.

module data_mem_rr_arbiter_lane #(
  parameter int NREQ = 4,
  parameter int IDX  = 0
) (
  input  logic                    req,
  input  logic [$clog2(NREQ)-1:0] lg,
  output logic                    hi
);
  localparam int IW = $clog2(NREQ);

  // Requester sits above the last winner, so it has priority this round.
  assign hi = req && (IW'(IDX) > lg);
endmodule

module data_mem_rr_arbiter #(
  parameter int NREQ   = 4,
  parameter int AW     = 8,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    we,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    rvalid,
  output logic [DW-1:0]      rdata,
  output logic               mem_en,
  output logic               mem_we,
  output logic [AW-1:0]      mem_addr,
  output logic [DW-1:0]      mem_wdata,
  input  logic [DW-1:0]      mem_rdata,
  output logic               busy
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(RD_LAT + 1);
  localparam logic [CW-1:0]   LAT_C = CW'(RD_LAT);
  localparam logic [NREQ-1:0] ONE   = NREQ'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } mem_req_t;

  state_t                    state;
  logic [IW-1:0]             lg;
  logic [CW-1:0]             cnt;
  logic [NREQ-1:0][AW-1:0]   addr_a;
  logic [NREQ-1:0][DW-1:0]   wdata_a;
  logic [NREQ-1:0]           hi;
  logic [IW-1:0]             win;
  logic                      found;
  mem_req_t                  cand;

  assign addr_a  = addr;
  assign wdata_a = wdata;
  assign busy    = (state != IDLE);

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    data_mem_rr_arbiter_lane #(.NREQ(NREQ), .IDX(i)) u_lane (
      .req (req[i]),
      .lg  (lg),
      .hi  (hi[i])
    );
  end

  // Lowest index above lg wins; otherwise wrap to the lowest requesting index.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++)
      if (hi[i] && !found) begin
        win   = IW'(i);
        found = 1'b1;
      end
    for (int i = 0; i < NREQ; i++)
      if (req[i] && !found) begin
        win   = IW'(i);
        found = 1'b1;
      end
    cand.we    = we[win];
    cand.addr  = addr_a[win];
    cand.wdata = wdata_a[win];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lg        <= IW'(NREQ - 1);
      cnt       <= '0;
      gnt       <= '0;
      rvalid    <= '0;
      rdata     <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      gnt    <= '0;
      rvalid <= '0;
      case (state)
        IDLE: if (|req) begin
          lg        <= win;
          gnt       <= ONE << win;
          mem_en    <= 1'b1;
          mem_we    <= cand.we;
          mem_addr  <= cand.addr;
          mem_wdata <= cand.wdata;
          state     <= ISSUE;
        end
        ISSUE: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          // mem_we still holds the captured access type during ISSUE.
          if (mem_we) state <= IDLE;
          else begin
            state <= WAIT;
            cnt   <= CW'(1);
          end
        end
        WAIT: begin
          // lg is the owner: it only moves on a grant, which cannot happen here.
          if (cnt == LAT_C) begin
            rdata  <= mem_rdata;
            rvalid <= ONE << lg;
            cnt    <= '0;
            state  <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
